// File: rtl/thermal_fb_pkg.sv
// Shared types and widths for the thermal sensor frame buffer and its SPI readout.
package thermal_fb_pkg;

   localparam int unsigned FB_DATA_WIDTH  = 8;
   localparam int unsigned FB_ADDR_WIDTH  = 14;
   localparam int unsigned FB_FRAME_BYTES = 768;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILL    = 2'd1,
      PENDING = 2'd2
   } fb_state_e;

endpackage

// File: rtl/cs_sync.sv
// Two-flop synchroniser bringing the SPI chip select into the hf_clk domain.
module cs_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/thermal_frame_buffer.sv
// Ping-pong frame buffer: pixel stream fills the back bank, SPI reads the front bank,
// banks swap only between SPI transactions so a host never sees a torn frame.
module thermal_frame_buffer
   import thermal_fb_pkg::*;
#(
   parameter int unsigned FRAME_BYTES = FB_FRAME_BYTES,
   parameter int unsigned ADDR_WIDTH  = FB_ADDR_WIDTH
) (
   input  logic                     hf_clk,
   input  logic                     resetn,
   input  logic [FB_DATA_WIDTH-1:0] pixel_data,
   input  logic                     pixel_valid,
   input  logic                     pixel_start,
   output logic                     pixel_ready,
   input  logic                     cs,
   input  logic [ADDR_WIDTH-1:0]    data_address,
   output logic [FB_DATA_WIDTH-1:0] data,
   output logic                     frame_valid,
   output logic [7:0]               frame_count,
   output logic                     frame_error
);

   localparam int unsigned MEM_DEPTH = 2 * FRAME_BYTES;
   localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] START_PTR_NEXT =
      (FRAME_BYTES == 1) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);

   fb_state_e               state_q, state_d;
   logic                    cs_s;
   logic                    accept_c;
   logic                    wr_en, swap, set_err;
   logic [ADDR_WIDTH-1:0]   write_ptr, ptr_d, wr_addr;
   logic                    bank_sel;
   logic                    in_range;
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic [FB_DATA_WIDTH-1:0] mem [MEM_DEPTH];

   // Bank b occupies entries [b*FRAME_BYTES, (b+1)*FRAME_BYTES).
   function automatic logic [MEM_AW-1:0] mem_idx(input logic bank,
                                                 input logic [ADDR_WIDTH-1:0] addr);
      return MEM_AW'(addr) + (bank ? MEM_AW'(FRAME_BYTES) : MEM_AW'(0));
   endfunction

   cs_sync u_cs_sync (
      .clk   (hf_clk),
      .rst_n (resetn),
      .d     (cs),
      .q     (cs_s)
   );

   assign accept_c = pixel_valid && (state_q != PENDING);

   always_ff @(posedge hf_clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_c && pixel_start)
                     state_d = (FRAME_BYTES == 1) ? PENDING : FILL;
         FILL:    if (accept_c && !pixel_start && write_ptr == LAST_IDX)
                     state_d = PENDING;
         PENDING: if (!cs_s) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Per-state handshake, write strobe and pointer/flag updates.
   always_comb begin
      pixel_ready = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = '0;
      ptr_d       = write_ptr;
      set_err     = 1'b0;
      swap        = 1'b0;
      case (state_q)
         IDLE: begin
            pixel_ready = 1'b1;
            if (accept_c) begin
               if (pixel_start) begin
                  wr_en = 1'b1;
                  ptr_d = START_PTR_NEXT;
               end else begin
                  set_err = 1'b1;
               end
            end
         end
         FILL: begin
            pixel_ready = 1'b1;
            if (accept_c) begin
               wr_en = 1'b1;
               if (pixel_start) begin
                  set_err = 1'b1;
                  ptr_d   = START_PTR_NEXT;
               end else begin
                  wr_addr = write_ptr;
                  ptr_d   = (write_ptr == LAST_IDX) ? '0 : write_ptr + ADDR_WIDTH'(1);
               end
            end
         end
         PENDING: swap = !cs_s;
         default: ;
      endcase
   end

   always_ff @(posedge hf_clk or negedge resetn) begin
      if (!resetn) begin
         write_ptr   <= '0;
         bank_sel    <= 1'b0;
         frame_valid <= 1'b0;
         frame_count <= '0;
         frame_error <= 1'b0;
      end else begin
         write_ptr <= ptr_d;
         if (swap) begin
            bank_sel    <= !bank_sel;
            frame_valid <= 1'b1;
            frame_count <= frame_count + 8'd1;
            frame_error <= 1'b0;
         end else if (set_err) begin
            frame_error <= 1'b1;
         end
      end
   end

   // Pixel storage is not reset; only the back bank is ever written.
   always_ff @(posedge hf_clk) begin
      if (wr_en) mem[mem_idx(!bank_sel, wr_addr)] <= pixel_data;
   end

   assign in_range = {1'b0, data_address} < (ADDR_WIDTH + 1)'(FRAME_BYTES);
   assign rd_addr  = in_range ? data_address : '0;
   assign data     = (frame_valid && in_range) ? mem[mem_idx(bank_sel, rd_addr)] : '0;

endmodule
